// File: rtl/peak_pkg.sv
// rtl/peak_pkg.sv - shared types for the peak-record frame sink
//
// Purpose: record layout, field indices and framing FSM state encoding
// used by peak_frame_sink and its bank sub-module.
// Contents:
//   PEAK_DW       stored width of each record field
//   FLD_*         word index of each field inside a peak (read address = peak*4 + field)
//   peak_rec_t    one stored peak record {freq, mag, phaseA, phaseB}
//   sink_state_t  framing FSM states
//   rec_field()   selects one field of a record by field index
package peak_pkg;

  localparam int PEAK_DW    = 32;
  localparam int NFIELDS    = 4;
  localparam int FLD_FREQ   = 0;
  localparam int FLD_MAG    = 1;
  localparam int FLD_PHASEA = 2;
  localparam int FLD_PHASEB = 3;

  typedef struct packed {
    logic [PEAK_DW-1:0] freq;
    logic [PEAK_DW-1:0] mag;
    logic [PEAK_DW-1:0] phaseA;
    logic [PEAK_DW-1:0] phaseB;
  } peak_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2
  } sink_state_t;

  function automatic logic [PEAK_DW-1:0] rec_field(input peak_rec_t rec, input logic [1:0] idx);
    logic [PEAK_DW-1:0] word;
    case (idx)
      2'(FLD_FREQ):   word = rec.freq;
      2'(FLD_MAG):    word = rec.mag;
      2'(FLD_PHASEA): word = rec.phaseA;
      default:        word = rec.phaseB;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/peak_frame_sink_if.sv
// rtl/peak_frame_sink_if.sv - peak-record stream bundle (sop/eop/valid + four fields)
//
// Purpose: groups the record stream feeding peak_frame_sink.
// Signals:
//   sink_sop     first record of a frame (qualified by sink_valid)
//   sink_eop     last record of a frame (qualified by sink_valid)
//   sink_valid   record present this cycle; there is no backpressure
//   sink_freq    peak frequency, kHz, two's complement, 8 fractional bits
//   sink_mag     peak magnitude
//   sink_phaseA  phase candidate A, deg
//   sink_phaseB  phase candidate B, deg
// Modports: master = record producer, slave = peak_frame_sink.
interface peak_frame_sink_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  sink_sop;
  logic                  sink_eop;
  logic                  sink_valid;
  logic [DATA_WIDTH-1:0] sink_freq;
  logic [DATA_WIDTH-1:0] sink_mag;
  logic [DATA_WIDTH-1:0] sink_phaseA;
  logic [DATA_WIDTH-1:0] sink_phaseB;

  modport master (
    output sink_sop, sink_eop, sink_valid,
    output sink_freq, sink_mag, sink_phaseA, sink_phaseB
  );

  modport slave (
    input sink_sop, sink_eop, sink_valid,
    input sink_freq, sink_mag, sink_phaseA, sink_phaseB
  );

endinterface

// File: rtl/peak_frame_sink_bank.sv
// rtl/peak_frame_sink_bank.sv - double-buffered peak record storage with registered read port
//
// Purpose: two NPEAKS-deep banks of peak_rec_t. One is the write bank the
// framing logic fills, the other is the read bank seen by the reader.
// swap_i exchanges their roles at the clock edge.
// Ports:
//   clk, reset     clock, synchronous active-high reset (zeroes both banks)
//   wr_en_i        write wr_rec_i into the write bank at wr_idx_i
//   wr_idx_i       record slot in the write bank
//   wr_rec_i       record to store
//   swap_i         exchange write and read banks
//   rd_en_i        read request
//   rd_addr_i      word address = peak*4 + field
//   rd_data_o      registered read word (holds when rd_en_i is low)
//   rd_valid_o     high the cycle after rd_en_i
module peak_bank
  import peak_pkg::*;
#(
  parameter  int NPEAKS = 4,
  localparam int AW     = $clog2(NPEAKS*NFIELDS),
  localparam int IW     = (NPEAKS > 1) ? $clog2(NPEAKS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en_i,
  input  logic [IW-1:0]      wr_idx_i,
  input  peak_rec_t          wr_rec_i,
  input  logic               swap_i,
  input  logic               rd_en_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [PEAK_DW-1:0] rd_data_o,
  output logic               rd_valid_o
);

  peak_rec_t          mem_q [2][NPEAKS];
  logic               wsel_q;      // index of the write bank; the read bank is ~wsel_q
  logic [PEAK_DW-1:0] rd_data_q;
  logic               rd_valid_q;
  logic [PEAK_DW-1:0] rd_word;

  // The read bank is addressed with the current select, so a read issued in
  // the swap cycle still returns the outgoing frame's word.
  always_comb begin
    rd_word = '0;
    if (int'(rd_addr_i) < NPEAKS*NFIELDS) begin
      rd_word = rec_field(mem_q[~wsel_q][rd_addr_i[AW-1:2]], rd_addr_i[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int p = 0; p < NPEAKS; p++) begin
          mem_q[b][p] <= '0;
        end
      end
      wsel_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_en_i) begin
        mem_q[wsel_q][wr_idx_i] <= wr_rec_i;
      end
      if (swap_i) begin
        wsel_q <= ~wsel_q;
      end
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= rd_word;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/peak_frame_sink.sv
// rtl/peak_frame_sink.sv - peak-record stream sink with framing checks and double-buffered frames
//
// Purpose: receives one peak record per cycle, checks sop/eop framing, gathers
// NPEAKS records into the write bank and commits only complete frames to the
// read bank. A reader fetches the committed frame over a 1-cycle read port
// and releases it with frame_ack.
// Build option: defining PEAK_SINK_TSTAMP_EN adds a free-running 32-bit cycle
// counter, stamps each frame at its accepted sop and exposes the read bank's
// stamp on frame_tstamp.
// Ports:
//   clk, reset     sole clock, synchronous active-high reset
//   sink           peak_frame_sink_if.slave record stream
//   rd_en          read request
//   rd_addr        word address = peak*4 + field (0 freq, 1 mag, 2 phaseA, 3 phaseB)
//   rd_data        read word from the committed bank, valid one cycle after rd_en
//   rd_valid       rd_data valid
//   frame_ready    committed frame not yet acknowledged (level)
//   frame_ack      reader done with the committed frame
//   frame_count    committed frames since reset, wraps
//   err_framing    sticky framing-error flag
//   err_overflow   sticky dropped-frame flag (frame completed while reader busy)
//   frame_tstamp   (PEAK_SINK_TSTAMP_EN only) sop stamp of the committed frame
module peak_frame_sink
  import peak_pkg::*;
#(
  parameter  int NPEAKS     = 4,
  parameter  int DATA_WIDTH = PEAK_DW,
  localparam int AW         = $clog2(NPEAKS*NFIELDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  peak_frame_sink_if.slave      sink,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  frame_ready,
  input  logic                  frame_ack,
  output logic [15:0]           frame_count,
  output logic                  err_framing,
  output logic                  err_overflow
`ifdef PEAK_SINK_TSTAMP_EN
  ,
  output logic [31:0]           frame_tstamp
`endif
);

  localparam int IW = (NPEAKS > 1) ? $clog2(NPEAKS) : 1;
  localparam int CW = $clog2(NPEAKS + 1);

  sink_state_t        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;     // records stored in the current frame
  logic               frame_ready_q;
  logic [15:0]        frame_count_q;
  logic               err_framing_q;
  logic               err_overflow_q;

  logic               wr_en;
  logic [IW-1:0]      wr_idx;
  logic [CW-1:0]      fill;             // record count after this cycle's store
  logic               commit;           // this cycle's record completes a good frame
  logic               framing_set;
  logic               commit_ok;
  logic               commit_drop;
  peak_rec_t          wr_rec;
  logic [PEAK_DW-1:0] bank_rd_data;
`ifdef PEAK_SINK_TSTAMP_EN
  logic               sop_accept;
`endif

  assign wr_rec = '{
    freq:   PEAK_DW'(sink.sink_freq),
    mag:    PEAK_DW'(sink.sink_mag),
    phaseA: PEAK_DW'(sink.sink_phaseA),
    phaseB: PEAK_DW'(sink.sink_phaseB)
  };

  // Framing FSM. A sop record always (re)starts a frame as record 0, whatever
  // the state; the trailing block decides the follow-on state for any stored
  // record from the post-store fill count and eop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    wr_idx      = '0;
    fill        = '0;
    commit      = 1'b0;
    framing_set = 1'b0;
`ifdef PEAK_SINK_TSTAMP_EN
    sop_accept  = 1'b0;
`endif
    if (sink.sink_valid) begin
      if (sink.sink_sop) begin
        framing_set = (state_q != ST_IDLE);
        wr_en       = 1'b1;
        wr_idx      = '0;
        fill        = CW'(1);
`ifdef PEAK_SINK_TSTAMP_EN
        sop_accept  = 1'b1;
`endif
      end else begin
        unique case (state_q)
          ST_COLLECT: begin
            wr_en  = 1'b1;
            wr_idx = IW'(cnt_q);
            fill   = cnt_q + CW'(1);
          end
          ST_DISCARD: begin
            if (sink.sink_eop) begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            // Record outside any frame.
            framing_set = 1'b1;
          end
        endcase
      end

      if (wr_en) begin
        cnt_d = '0;
        if (sink.sink_eop) begin
          state_d = ST_IDLE;
          if (fill == CW'(NPEAKS)) begin
            commit = 1'b1;
          end else begin
            framing_set = 1'b1;
          end
        end else if (fill == CW'(NPEAKS)) begin
          // Bank full without eop: drop the rest of this frame.
          state_d = ST_DISCARD;
        end else begin
          state_d = ST_COLLECT;
          cnt_d   = fill;
        end
      end
    end
  end

  // The final record is written and the banks swap on the same edge, so the
  // completed frame is readable from the very next cycle. An ack arriving with
  // the commit frees the read bank just in time to take the new frame.
  assign commit_ok   = commit && (!frame_ready_q || frame_ack);
  assign commit_drop = commit && frame_ready_q && !frame_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      frame_ready_q  <= 1'b0;
      frame_count_q  <= '0;
      err_framing_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit_ok) begin
        frame_ready_q <= 1'b1;
        frame_count_q <= frame_count_q + 16'd1;
      end else if (frame_ack) begin
        frame_ready_q <= 1'b0;
      end
      if (framing_set) begin
        err_framing_q <= 1'b1;
      end
      if (commit_drop) begin
        err_overflow_q <= 1'b1;
      end
    end
  end

  peak_bank #(
    .NPEAKS(NPEAKS)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_rec_i  (wr_rec),
    .swap_i    (commit_ok),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (bank_rd_data),
    .rd_valid_o(rd_valid)
  );

  assign rd_data      = DATA_WIDTH'(bank_rd_data);
  assign frame_ready  = frame_ready_q;
  assign frame_count  = frame_count_q;
  assign err_framing  = err_framing_q;
  assign err_overflow = err_overflow_q;

`ifdef PEAK_SINK_TSTAMP_EN
  // Stamps travel with the banks: stamp_sel_q mirrors the bank write select.
  logic [31:0] cyc_q;
  logic [31:0] stamp_q [2];
  logic        stamp_sel_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q       <= '0;
      stamp_q[0]  <= '0;
      stamp_q[1]  <= '0;
      stamp_sel_q <= 1'b0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (sop_accept) begin
        stamp_q[stamp_sel_q] <= cyc_q;
      end
      if (commit_ok) begin
        stamp_sel_q <= ~stamp_sel_q;
      end
    end
  end

  assign frame_tstamp = stamp_q[~stamp_sel_q];
`endif

endmodule

// File: tb/tb_peak_frame_sink.sv
// tb/tb_peak_frame_sink.sv - directed and randomized self-checking bench for peak_frame_sink
module tb_peak_frame_sink;
  import peak_pkg::*;

  logic        clk;
  logic        reset;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        frame_ready;
  logic        frame_ack;
  logic [15:0] frame_count;
  logic        err_framing;
  logic        err_overflow;
`ifdef PEAK_SINK_TSTAMP_EN
  logic [31:0] frame_tstamp;
`endif

  peak_frame_sink_if #(.DATA_WIDTH(32)) sif ();

  peak_frame_sink #(
    .NPEAKS(4),
    .DATA_WIDTH(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sink        (sif),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .frame_count (frame_count),
    .err_framing (err_framing),
    .err_overflow(err_overflow)
`ifdef PEAK_SINK_TSTAMP_EN
    ,
    .frame_tstamp(frame_tstamp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the committed frame and status.
  peak_rec_t mrb [4];
  logic      mready;
  int        mcount;
  logic      mferr;
  logic      moerr;

  peak_rec_t fr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic peak_rec_t rand_rec();
    peak_rec_t r;
    r.freq   = $urandom;
    r.mag    = $urandom;
    r.phaseA = $urandom;
    r.phaseB = $urandom;
    return r;
  endfunction

  function automatic peak_rec_t mk(input logic [31:0] f);
    peak_rec_t r;
    r      = rand_rec();
    r.freq = f;
    return r;
  endfunction

  function automatic logic [31:0] exp_word(input int addr);
    peak_rec_t r;
    r = mrb[addr / 4];
    case (addr % 4)
      0:       return r.freq;
      1:       return r.mag;
      2:       return r.phaseA;
      default: return r.phaseB;
    endcase
  endfunction

  task automatic fill_frame(input int n);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(rand_rec());
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input peak_rec_t r,
                       input logic ack, input logic re, input logic [3:0] ra);
    @(negedge clk);
    sif.sink_valid  = v;
    sif.sink_sop    = s;
    sif.sink_eop    = e;
    sif.sink_freq   = r.freq;
    sif.sink_mag    = r.mag;
    sif.sink_phaseA = r.phaseA;
    sif.sink_phaseB = r.phaseB;
    frame_ack       = ack;
    rd_en           = re;
    rd_addr         = ra;
  endtask

  task automatic idle(input logic ack);
    drive(1'b0, 1'b0, 1'b0, '0, ack, 1'b0, 4'd0);
  endtask

  task automatic send(input peak_rec_t recs[$], input logic with_sop, input logic with_eop,
                      input logic ack_last);
    for (int i = 0; i < recs.size(); i++) begin
      drive(1'b1, with_sop && (i == 0), with_eop && (i == recs.size() - 1), recs[i],
            ack_last && (i == recs.size() - 1), 1'b0, 4'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(1'b0);
    idle(1'b0);
    reset = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, a);
    idle(1'b0);
    chk({tag, "_rdv"}, 32'(rd_valid), 32'd1);
    chk(tag, rd_data, exp);
  endtask

  task automatic chk_status(input string tag, input logic rdy, input int cnt,
                            input logic fe, input logic oe);
    chk({tag, "_ready"}, 32'(frame_ready), 32'(rdy));
    chk({tag, "_count"}, 32'(frame_count), 32'(16'(cnt)));
    chk({tag, "_ferr"}, 32'(err_framing), 32'(fe));
    chk({tag, "_oerr"}, 32'(err_overflow), 32'(oe));
  endtask

  task automatic model_commit(input peak_rec_t recs[$], input logic ack);
    if (!mready || ack) begin
      mready = 1'b1;
      mcount++;
      for (int i = 0; i < 4; i++) mrb[i] = recs[i];
    end else begin
      moerr = 1'b1;
    end
  endtask

  initial begin
    peak_rec_t fa[$];
    peak_rec_t fb[$];
    peak_rec_t fc[$];
    peak_rec_t fd[$];
    peak_rec_t tmp[$];
    int        kind;
    int        n;
    int        gaps;
    logic      a;
    logic [3:0] ra;

    reset           = 1'b1;
    rd_en           = 1'b0;
    rd_addr         = '0;
    frame_ack       = 1'b0;
    sif.sink_valid  = 1'b0;
    sif.sink_sop    = 1'b0;
    sif.sink_eop    = 1'b0;
    sif.sink_freq   = '0;
    sif.sink_mag    = '0;
    sif.sink_phaseA = '0;
    sif.sink_phaseB = '0;

    do_reset();
    chk_status("reset", 1'b0, 0, 1'b0, 1'b0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);

    // Short frame: 3 records then eop.
    tmp = {mk(32'd1 << 8), mk(32'd2 << 8), mk(32'd3 << 8)};
    send(tmp, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    chk_status("short", 1'b0, 0, 1'b1, 1'b0);

    do_reset();
    chk("reset2_ferr", 32'(err_framing), 32'd0);

    // First clean frame.
    fa = {mk(32'd2000 << 8), mk(32'd4000 << 8), mk(32'd6000 << 8), mk(32'd8000 << 8)};
    send(fa, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    chk_status("frame1", 1'b1, 1, 1'b0, 1'b0);
    rd_chk("frame1_addr4", 4'd4, 32'd4000 << 8);
    idle(1'b0);
    chk("noread_rdv", 32'(rd_valid), 32'd0);
    chk("noread_hold", rd_data, 32'd4000 << 8);

    // Second frame with ack on its final record: accepted.
    fill_frame(4);
    fc = fr;
    send(fc, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    chk_status("ackcommit", 1'b1, 2, 1'b0, 1'b0);
    rd_chk("ackcommit_addr0", 4'd0, fc[0].freq);
    rd_chk("ackcommit_addr15", 4'd15, fc[3].phaseB);

    // Third frame, no ack: dropped.
    fill_frame(4);
    fb = fr;
    send(fb, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    chk_status("overflow", 1'b1, 2, 1'b0, 1'b1);
    rd_chk("overflow_addr0", 4'd0, fc[0].freq);
    rd_chk("overflow_addr6", 4'd6, fc[1].phaseA);

    // Ack clears ready; a second ack while idle changes nothing.
    idle(1'b1);
    idle(1'b0);
    chk("ack_clear", 32'(frame_ready), 32'd0);
    idle(1'b1);
    idle(1'b0);
    chk_status("ack_idle", 1'b0, 2, 1'b0, 1'b1);

    // sop after 2 records, then a clean frame; read in the swap cycle sees old bank.
    fill_frame(2);
    send(fr, 1'b1, 1'b0, 1'b0);
    fill_frame(4);
    fd = fr;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, i == 3, fd[i], 1'b0, i == 3, 4'd0);
    end
    idle(1'b0);
    chk("swapread_rdv", 32'(rd_valid), 32'd1);
    chk("swapread_old", rd_data, fc[0].freq);
    chk_status("restart", 1'b1, 3, 1'b1, 1'b1);
    rd_chk("restart_addr12", 4'd12, fd[3].freq);
    rd_chk("restart_addr5", 4'd5, fd[1].mag);

    // Reset mid-frame.
    fill_frame(2);
    send(fr, 1'b1, 1'b0, 1'b0);
    do_reset();
    chk_status("midreset", 1'b0, 0, 1'b0, 1'b0);
    chk("midreset_rd_data", rd_data, 32'd0);
    chk("midreset_rd_valid", 32'(rd_valid), 32'd0);
    rd_chk("midreset_bank0", 4'd0, 32'd0);
    fill_frame(4);
    fa = fr;
    send(fa, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    chk_status("postreset", 1'b1, 1, 1'b0, 1'b0);
    rd_chk("postreset_addr8", 4'd8, fa[2].freq);

`ifdef PEAK_SINK_TSTAMP_EN
    do_reset();
    chk("tstamp_reset", frame_tstamp, 32'd0);
    for (int i = 0; i < 9; i++) idle(1'b0);
    fill_frame(4);
    send(fr, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    chk("tstamp_sop10", frame_tstamp, 32'd10);
`endif

    // Randomized frames against the reference model.
    do_reset();
    for (int i = 0; i < 4; i++) mrb[i] = '0;
    mready = 1'b0;
    mcount = 0;
    mferr  = 1'b0;
    moerr  = 1'b0;
    for (int it = 0; it < 150; it++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: begin
          fill_frame(4);
          a = 1'($urandom_range(0, 1));
          send(fr, 1'b1, 1'b1, a);
          model_commit(fr, a);
        end
        1: begin
          n = int'($urandom_range(1, 3));
          fill_frame(n);
          send(fr, 1'b1, 1'b1, 1'b0);
          mferr = 1'b1;
        end
        2: begin
          n = int'($urandom_range(1, 2));
          fill_frame(n);
          send(fr, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
          mferr = 1'b1;
        end
        default: begin
          n = int'($urandom_range(1, 3));
          fill_frame(n);
          send(fr, 1'b1, 1'b0, 1'b0);
          mferr = 1'b1;
          fill_frame(4);
          a = 1'($urandom_range(0, 1));
          send(fr, 1'b1, 1'b1, a);
          model_commit(fr, a);
        end
      endcase
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        a = 1'($urandom_range(0, 1));
        idle(a);
        if (a) mready = 1'b0;
      end
      idle(1'b0);
      chk_status("rnd", mready, mcount, mferr, moerr);
      ra = 4'($urandom_range(0, 15));
      rd_chk("rnd_rd", ra, exp_word(int'(ra)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
